// File: rtl/axis2tap_pkg.sv
// Shared defaults and writer state encoding for the AXIS packet FIFO.
package axis2tap_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_DEPTH_LOG2 = 9;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        WRITE,
        DISCARD
    } wr_state_e;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
module axis_fifo_ram #(
    parameter int WIDTH = 73,
    parameter int AW    = 9
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXIS packet FIFO; only complete, error-free frames
// reach TX. Bad and overflowing frames are dropped whole and counted.
module axis_pkt_fifo
    import axis2tap_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_rx_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_rx_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_rx_tkeep,
    input  logic                  s_axis_rx_tlast,
    input  logic                  s_axis_rx_tuser,
    input  logic                  m_axis_tx_tready,
    output logic                  m_axis_tx_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tx_tkeep,
    output logic                  m_axis_tx_tlast,
    output logic                  m_axis_tx_tuser,
    output logic [CNT_WIDTH-1:0]  stat_frames_ok,
    output logic [CNT_WIDTH-1:0]  stat_drop_bad,
    output logic [CNT_WIDTH-1:0]  stat_drop_ovf
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PW-1:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    wr_state_e state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_commit_q, wr_commit_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          tvalid_q, tvalid_d;
    logic [CNT_WIDTH-1:0] ok_q, ok_d;
    logic [CNT_WIDTH-1:0] bad_q, bad_d;
    logic [CNT_WIDTH-1:0] ovf_q, ovf_d;

    logic          full;
    logic          empty;
    logic          we;
    logic          rd_en;
    logic [EW-1:0] rd_data;

    // Full uses rd_ptr before this cycle's read: conservative by design.
    assign full  = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
    assign empty = (rd_ptr_q == wr_commit_q);
    assign rd_en = !empty && (!tvalid_q || m_axis_tx_tready);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        ok_d        = ok_q;
        bad_d       = bad_q;
        ovf_d       = ovf_q;
        we          = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (!s_axis_rx_tvalid || s_axis_rx_tlast) begin
                    state_d = IDLE;
                end
            end
            IDLE, WRITE: begin
                if (s_axis_rx_tvalid) begin
                    if (full) begin
                        wr_ptr_d = wr_commit_q;
                        ovf_d    = ovf_q + CNT_WIDTH'(1);
                        state_d  = s_axis_rx_tlast ? IDLE : DISCARD;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (!s_axis_rx_tlast) begin
                            state_d = WRITE;
                        end else if (s_axis_rx_tuser) begin
                            wr_ptr_d = wr_commit_q;
                            bad_d    = bad_q + CNT_WIDTH'(1);
                            state_d  = IDLE;
                        end else begin
                            wr_commit_d = wr_ptr_q + PW'(1);
                            ok_d        = ok_q + CNT_WIDTH'(1);
                            state_d     = IDLE;
                        end
                    end
                end
            end
            DISCARD: begin
                if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        tvalid_d = tvalid_q;
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            tvalid_d = 1'b1;
        end else if (m_axis_tx_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            tvalid_q    <= 1'b0;
            ok_q        <= '0;
            bad_q       <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            tvalid_q    <= tvalid_d;
            ok_q        <= ok_d;
            bad_q       <= bad_d;
            ovf_q       <= ovf_d;
        end
    end

    // The RAM read register doubles as the TX output register.
    axis_fifo_ram #(
        .WIDTH (EW),
        .AW    (DEPTH_LOG2)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (we),
        .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_data_i ({s_axis_rx_tlast, s_axis_rx_tkeep, s_axis_rx_tdata}),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data_o (rd_data)
    );

    assign m_axis_tx_tvalid = tvalid_q;
    assign m_axis_tx_tdata  = rd_data[DATA_WIDTH-1:0];
    assign m_axis_tx_tkeep  = rd_data[DATA_WIDTH+KEEP_WIDTH-1:DATA_WIDTH];
    assign m_axis_tx_tlast  = rd_data[EW-1];
    assign m_axis_tx_tuser  = 1'b0;
    assign stat_frames_ok   = ok_q;
    assign stat_drop_bad    = bad_q;
    assign stat_drop_ovf    = ovf_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo with a small buffer (16 beats).
module tb_axis_pkt_fifo;

    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int DL  = 4;
    localparam int CW  = 32;
    localparam int CAP = 16;

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_tvalid = 1'b0;
    logic [DW-1:0] rx_tdata = '0;
    logic [KW-1:0] rx_tkeep = '0;
    logic          rx_tlast = 1'b0;
    logic          rx_tuser = 1'b0;
    logic          tx_tready = 1'b1;
    logic          tx_tvalid;
    logic [DW-1:0] tx_tdata;
    logic [KW-1:0] tx_tkeep;
    logic          tx_tlast;
    logic          tx_tuser;
    logic [CW-1:0] st_ok, st_bad, st_ovf;

    beat_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int exp_ok = 0, exp_bad = 0, exp_ovf = 0;
    int tx_beats = 0;
    int rdy_mode = 0;
    logic rdy_fix = 1'b1;
    logic hold_pending = 1'b0;
    beat_t held;

    axis_pkt_fifo #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .DEPTH_LOG2 (DL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_rx_tvalid (rx_tvalid),
        .s_axis_rx_tdata  (rx_tdata),
        .s_axis_rx_tkeep  (rx_tkeep),
        .s_axis_rx_tlast  (rx_tlast),
        .s_axis_rx_tuser  (rx_tuser),
        .m_axis_tx_tready (tx_tready),
        .m_axis_tx_tvalid (tx_tvalid),
        .m_axis_tx_tdata  (tx_tdata),
        .m_axis_tx_tkeep  (tx_tkeep),
        .m_axis_tx_tlast  (tx_tlast),
        .m_axis_tx_tuser  (tx_tuser),
        .stat_frames_ok   (st_ok),
        .stat_drop_bad    (st_bad),
        .stat_drop_ovf    (st_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Sink ready pattern: 0 fixed, 1 toggling, 2 random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_tready = rdy_fix;
                1:       tx_tready = ~tx_tready;
                default: tx_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every TX handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("tx_hold", {tx_tvalid, tx_tlast, tx_tkeep, tx_tdata},
                    {1'b1, held});
                hold_pending = 1'b0;
            end
            if (tx_tvalid) begin
                if (tx_tuser !== 1'b0) begin
                    chk("tx_tuser", 128'(tx_tuser), 128'(0));
                end
                if (tx_tready) begin
                    tx_beats++;
                    if (exp_q.size() == 0) begin
                        chk("tx_unexpected", 128'({tx_tlast, tx_tkeep, tx_tdata}), 128'(0));
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        chk("tx_beat", {tx_tlast, tx_tkeep, tx_tdata}, e);
                    end
                end else begin
                    hold_pending = 1'b1;
                    held = {tx_tlast, tx_tkeep, tx_tdata};
                end
            end
        end
    end

    task automatic drive_beat(input int i, input int len, input bit bad,
                              input logic [KW-1:0] lkeep, output beat_t b);
        b.data = {$urandom, $urandom};
        b.last = (i == len - 1);
        if (!b.last) b.keep = '1;
        else if (lkeep != 0) b.keep = lkeep;
        else b.keep = KW'($urandom_range(1, 255));
        rx_tvalid = 1'b1;
        rx_tdata  = b.data;
        rx_tkeep  = b.keep;
        rx_tlast  = b.last;
        rx_tuser  = b.last ? bad : 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input int len, input bit bad, input bit fwd,
                              input bit gaps, input logic [KW-1:0] lkeep);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            drive_beat(i, len, bad, lkeep, b);
            if (fwd) exp_q.push_back(b);
            @(posedge clk);
            #1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                rx_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || tx_tvalid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_ok"},  128'(st_ok),  128'(exp_ok));
        chk({tag, "_bad"}, 128'(st_bad), 128'(exp_bad));
        chk({tag, "_ovf"}, 128'(st_ovf), 128'(exp_ovf));
    endtask

    initial begin
        int base;
        int len;
        int n;
        bit bad;
        beat_t b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 128'(tx_tvalid), 128'(0));
        check_stats("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single 4-beat frame and commit-to-valid latency.
        send_frame(4, 1'b0, 1'b1, 1'b0, 8'h0F);
        exp_ok++;
        @(negedge clk);
        chk("lat_edge0", 128'(tx_tvalid), 128'(0));
        @(negedge clk);
        chk("lat_edge1", 128'(tx_tvalid), 128'(1));
        wait_drain();
        check_stats("t1");

        // Bad frame then good frame.
        send_frame(3, 1'b1, 1'b0, 1'b0, 8'h00);
        exp_bad++;
        send_frame(2, 1'b0, 1'b1, 1'b0, 8'h00);
        exp_ok++;
        wait_drain();
        check_stats("t2");

        // Second 10-beat frame cannot fit while the sink stalls.
        rdy_fix = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = tx_beats;
        send_frame(10, 1'b0, 1'b1, 1'b0, 8'h00);
        exp_ok++;
        send_frame(10, 1'b0, 1'b0, 1'b0, 8'h00);
        exp_ovf++;
        repeat (4) @(posedge clk);
        #1;
        check_stats("t3");
        rdy_fix = 1'b1;
        wait_drain();
        chk("t3_tx_beats", 128'(tx_beats - base), 128'(10));

        // Oversized frame goes through DISCARD, counted once.
        send_frame(20, 1'b0, 1'b0, 1'b0, 8'h00);
        exp_ovf++;
        send_frame(1, 1'b0, 1'b1, 1'b0, 8'h00);
        exp_ok++;
        wait_drain();
        check_stats("t4");

        // Back-to-back single-beat frames with toggling ready.
        rdy_mode = 1;
        base = tx_beats;
        for (int i = 0; i < 12; i++) begin
            drive_beat(0, 1, 1'b0, 8'h00, b);
            exp_q.push_back(b);
            @(posedge clk);
            #1;
        end
        rx_tvalid = 1'b0;
        exp_ok += 12;
        wait_drain();
        chk("t5_tx_beats", 128'(tx_beats - base), 128'(12));
        check_stats("t5");

        // Random frames, throttled so the buffer can never overflow.
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            bad = ($urandom_range(0, 3) == 0);
            n = 0;
            while (exp_q.size() + len + 1 > CAP && n < 500) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 500) begin
                checks++;
                failures++;
                $display("FAIL rand_throttle actual=%0d required<=%0d",
                         exp_q.size(), CAP - len - 1);
            end
            send_frame(len, bad, !bad, 1'b1, 8'h00);
            if (bad) exp_bad++;
            else exp_ok++;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();
        check_stats("t6");

        // Reset in the middle of an RX frame; tail must be dropped.
        rdy_mode = 0;
        rdy_fix  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_beat(i, 8, 1'b0, 8'h00, b);
            if (i == 3) rst = 1'b1;
            if (i == 5) rst = 1'b0;
            if (i == 4) begin
                @(negedge clk);
                chk("t7_rst_tvalid", 128'(tx_tvalid), 128'(0));
                chk("t7_rst_ok", 128'(st_ok), 128'(0));
                chk("t7_rst_ovf", 128'(st_ovf), 128'(0));
            end
            @(posedge clk);
            #1;
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        exp_ok  = 0;
        exp_bad = 0;
        exp_ovf = 0;
        @(posedge clk);
        #1;
        send_frame(3, 1'b0, 1'b1, 1'b0, 8'h00);
        exp_ok++;
        wait_drain();
        check_stats("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
